// File: rtl/sfm_pkg.sv
// Shared softmax types: control/flag bundles, FSM states, command bits.
// Ports: none (package).
package sfm_pkg;

   localparam int unsigned ELEMS_PER_BEAT_DEF = 8;

   localparam int unsigned CMD_ACC_ONLY = 0;
   localparam int unsigned CMD_DIV_ONLY = 1;
   localparam int unsigned CMD_LAST     = 2;

   typedef enum logic [2:0] {
      IDLE, LOAD, ACC, DRAIN, FIN, RED, DIV
   } sfm_ctrl_state_t;

   typedef struct packed {
      logic        acc_only;
      logic        load_reciprocal;
      logic [31:0] reciprocal;
   } accumulator_ctrl_t;

   typedef struct packed {
      logic              clear_regs;
      logic              acc_finished;
      logic              load_max;
      logic              load_denominator;
      logic              disable_max;
      logic              dividing;
      logic [31:0]       max;
      logic [31:0]       denominator;
      accumulator_ctrl_t accumulator_ctrl;
   } datapath_ctrl_t;

   typedef struct packed {
      logic        acc_done;
      logic        inv_done;
      logic [31:0] denominator;
   } accumulator_flags_t;

   typedef struct packed {
      logic               datapath_busy;
      logic [31:0]        max;
      accumulator_flags_t accumulator_flags;
   } datapath_flags_t;

   // ceil(len / 2**sh), one extra bit so a full 32-bit length cannot wrap
   function automatic logic [32:0] beats_of(input logic [31:0] len,
                                            input int unsigned sh);
      logic [32:0] round;
      round = (33'd1 << sh) - 33'd1;
      return ({1'b0, len} + round) >> sh;
   endfunction

endpackage

// File: rtl/sfm_beat_counter.sv
// Saturating beat counter: clear, enable, target; reports reached and last step.
// Ports: clk, rst, clear, enable, target -> reached, last_step.
module sfm_beat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] target,
   output logic             reached,
   output logic             last_step
);

   logic [CNT_W-1:0] count;

   assign reached   = (count >= target);
   // the beat accepted this cycle is the one that lands on target
   assign last_step = enable && !reached &&
                      ((count + CNT_W'(1)) == target);

   always_ff @(posedge clk) begin
      if (rst || clear)
         count <= '0;
      else if (enable && !reached)
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/sfm_datapath_ctrl.sv
// Softmax datapath control FSM: sequences accumulate/divide over a stream.
// Ports: clk_i, rst_i, start_i, tot_len_i, commands_i, max_i, denominator_i,
//   in_beat_i, out_beat_i, flags_i -> in_req_o, out_req_o, ctrl_o, busy_o,
//   done_o, max_o, denominator_o, cycles_o (live only with SFM_CTRL_PERF_CNT_EN).
module sfm_datapath_ctrl
   import sfm_pkg::*;
#(
   parameter int unsigned ELEMS_PER_BEAT = ELEMS_PER_BEAT_DEF,
   parameter int unsigned CNT_W          = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic [31:0]     tot_len_i,
   input  logic [2:0]      commands_i,
   input  logic [31:0]     max_i,
   input  logic [31:0]     denominator_i,
   input  logic            in_beat_i,
   input  logic            out_beat_i,
   input  datapath_flags_t flags_i,
   output logic            in_req_o,
   output logic            out_req_o,
   output datapath_ctrl_t  ctrl_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [31:0]     max_o,
   output logic [31:0]     denominator_o,
   output logic [CNT_W-1:0] cycles_o
);

   localparam int unsigned SH = $clog2(ELEMS_PER_BEAT);

   sfm_ctrl_state_t  state;
   logic [CNT_W-1:0] beats_q;
   logic             acc_only_q;
   logic             last_q;
   logic             first_q;

   logic accept, acc_only_d, go_div, in_clear;
   logic in_reached, in_step, out_reached, out_step;
   logic in_hit, out_hit;

   // a start landing on the done cycle is dropped
   assign accept     = (state == IDLE) && start_i && !done_o;
   assign acc_only_d = commands_i[CMD_ACC_ONLY] &
                       ~commands_i[CMD_DIV_ONLY];
   assign go_div     = (state == RED) && !acc_only_q &&
                       flags_i.accumulator_flags.inv_done;
   // the divide pass re-streams the input, so in_cnt restarts
   assign in_clear   = accept | go_div;
   assign in_hit     = in_reached | in_step;
   assign out_hit    = out_reached | out_step;

   sfm_beat_counter #(.CNT_W(CNT_W)) u_in_cnt (
      .clk       (clk_i),
      .rst       (rst_i),
      .clear     (in_clear),
      .enable    (in_beat_i & in_req_o),
      .target    (beats_q),
      .reached   (in_reached),
      .last_step (in_step)
   );

   sfm_beat_counter #(.CNT_W(CNT_W)) u_out_cnt (
      .clk       (clk_i),
      .rst       (rst_i),
      .clear     (accept),
      .enable    (out_beat_i & out_req_o),
      .target    (beats_q),
      .reached   (out_reached),
      .last_step (out_step)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         beats_q       <= '0;
         acc_only_q    <= 1'b0;
         last_q        <= 1'b0;
         first_q       <= 1'b1;
         in_req_o      <= 1'b0;
         out_req_o     <= 1'b0;
         ctrl_o        <= '0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         max_o         <= '0;
         denominator_o <= '0;
      end else begin
         done_o                  <= 1'b0;
         ctrl_o.clear_regs       <= 1'b0;
         ctrl_o.acc_finished     <= 1'b0;
         ctrl_o.load_max         <= 1'b0;
         ctrl_o.load_denominator <= 1'b0;
         ctrl_o.max              <= '0;
         ctrl_o.denominator      <= '0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  beats_q    <= CNT_W'(beats_of(tot_len_i, SH));
                  acc_only_q <= acc_only_d;
                  last_q     <= commands_i[CMD_LAST];
                  if (tot_len_i == 32'd0) begin
                     done_o  <= 1'b1;
                     first_q <= commands_i[CMD_LAST];
                  end else begin
                     if (!commands_i[CMD_LAST])
                        first_q <= 1'b0;
                     busy_o <= 1'b1;
                     ctrl_o.accumulator_ctrl.acc_only <= acc_only_d;
                     if (commands_i[CMD_DIV_ONLY]) begin
                        state                   <= LOAD;
                        ctrl_o.load_max         <= 1'b1;
                        ctrl_o.load_denominator <= 1'b1;
                        ctrl_o.max              <= max_i;
                        ctrl_o.denominator      <= denominator_i;
                     end else begin
                        state             <= ACC;
                        in_req_o          <= 1'b1;
                        ctrl_o.clear_regs <= first_q;
                     end
                  end
               end
            end
            LOAD: begin
               state               <= FIN;
               ctrl_o.acc_finished <= 1'b1;
            end
            ACC: begin
               if (in_hit) begin
                  state    <= DRAIN;
                  in_req_o <= 1'b0;
               end
            end
            DRAIN: begin
               if (!flags_i.datapath_busy) begin
                  state               <= FIN;
                  ctrl_o.acc_finished <= 1'b1;
               end
            end
            FIN: state <= RED;
            RED: begin
               if (acc_only_q) begin
                  if (flags_i.accumulator_flags.acc_done) begin
                     max_o         <= flags_i.max;
                     denominator_o <= flags_i.accumulator_flags.denominator;
                     done_o        <= 1'b1;
                     busy_o        <= 1'b0;
                     state         <= IDLE;
                     ctrl_o.accumulator_ctrl.acc_only <= 1'b0;
                     if (last_q)
                        first_q <= 1'b1;
                  end
               end else if (go_div) begin
                  state              <= DIV;
                  in_req_o           <= 1'b1;
                  out_req_o          <= 1'b1;
                  ctrl_o.disable_max <= 1'b1;
                  ctrl_o.dividing    <= 1'b1;
               end
            end
            DIV: begin
               in_req_o  <= !in_hit;
               out_req_o <= !out_hit;
               if (out_reached && !flags_i.datapath_busy) begin
                  done_o             <= 1'b1;
                  busy_o             <= 1'b0;
                  state              <= IDLE;
                  in_req_o           <= 1'b0;
                  out_req_o          <= 1'b0;
                  ctrl_o.disable_max <= 1'b0;
                  ctrl_o.dividing    <= 1'b0;
                  ctrl_o.accumulator_ctrl.acc_only <= 1'b0;
                  if (last_q)
                     first_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SFM_CTRL_PERF_CNT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i || accept)
         cycles_o <= '0;
      else if (busy_o)
         cycles_o <= cycles_o + CNT_W'(1);
   end
`else
   assign cycles_o = '0;
`endif

endmodule

// File: tb/tb_sfm_datapath_ctrl.sv
// Self-checking bench for sfm_datapath_ctrl with randomized commands.
// Ports: none (top-level bench).
module tb_sfm_datapath_ctrl;
   import sfm_pkg::*;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [31:0]     tot_len;
   logic [2:0]      commands;
   logic [31:0]     max_in, den_in;
   logic            in_beat, out_beat;
   datapath_flags_t flags;
   logic            in_req, out_req, busy, done;
   datapath_ctrl_t  ctrl;
   logic [31:0]     max_out, den_out;
   logic [31:0]     cycles;

   int checks = 0;
   int errors = 0;
   bit model_first = 1'b1;
   logic [31:0] exp_max = '0;
   logic [31:0] exp_den = '0;

   always #5 clk = ~clk;

   sfm_datapath_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .tot_len_i     (tot_len),
      .commands_i    (commands),
      .max_i         (max_in),
      .denominator_i (den_in),
      .in_beat_i     (in_beat),
      .out_beat_i    (out_beat),
      .flags_i       (flags),
      .in_req_o      (in_req),
      .out_req_o     (out_req),
      .ctrl_o        (ctrl),
      .busy_o        (busy),
      .done_o        (done),
      .max_o         (max_out),
      .denominator_o (den_out),
      .cycles_o      (cycles)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      start    = 1'b0;
      in_beat  = 1'b0;
      out_beat = 1'b0;
      flags    = '0;
   endtask

   task automatic run_cmd(input int len, input logic [2:0] cmd,
                          input logic [31:0] mx, input logic [31:0] dn,
                          input bit poke);
      int beats = (len + 7) / 8;
      bit div_only = cmd[1];
      bit acc_only = cmd[0] & ~cmd[1];
      int exp_in  = (div_only ? 0 : beats) + (acc_only ? 0 : beats);
      int exp_out = acc_only ? 0 : beats;
      int exp_clr = (!div_only && model_first) ? 1 : 0;
      logic [31:0] fmax = $urandom;
      logic [31:0] fden = $urandom;
      int nin = 0, nout = 0, nclr = 0, nload = 0, nfin = 0;
      int ndone = 0, nbusy = 0, nacc_bad = 0;
      bit seen_fin = 0, seen_div = 0, seen_out = 0, fin = 0;
      logic [31:0] lmax = '0, lden = '0;
      @(negedge clk);
      start = 1'b1; tot_len = len; commands = cmd;
      max_in = mx; den_in = dn;
      flags.max = fmax;
      flags.accumulator_flags.denominator = fden;
      if (!cmd[2]) model_first = 1'b0;
      for (int n = 0; n < 3000 && !fin; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (ctrl.clear_regs) nclr++;
         if (ctrl.load_max && ctrl.load_denominator) begin
            nload++; lmax = ctrl.max; lden = ctrl.denominator;
         end
         if (ctrl.acc_finished) begin nfin++; seen_fin = 1; end
         if (ctrl.dividing) seen_div = 1;
         if (out_req) seen_out = 1;
         if (busy) nbusy++;
         if (busy && ctrl.accumulator_ctrl.acc_only !== acc_only)
            nacc_bad++;
         if (done) begin ndone++; fin = 1; end
         if (poke && n == 3) begin
            start = 1'b1; tot_len = len + 64; commands = 3'b000;
         end
         in_beat  = !fin && in_req && ($urandom_range(0, 2) != 0);
         out_beat = !fin && out_req && ($urandom_range(0, 2) != 0);
         if (in_beat) nin++;
         if (out_beat) nout++;
         flags.datapath_busy = !fin && ($urandom_range(0, 3) == 0);
         flags.accumulator_flags.acc_done = seen_fin && acc_only && !fin;
         flags.accumulator_flags.inv_done = seen_fin && !acc_only &&
                                            !seen_div && !fin;
      end
      idle_inputs();
      chk("done_seen", ndone, 1);
      chk("in_beats", nin, exp_in);
      chk("out_beats", nout, exp_out);
      chk("clear_regs", nclr, exp_clr);
      chk("load_pulse", nload, div_only ? 1 : 0);
      if (div_only) begin
         chk("load_max_val", lmax, mx);
         chk("load_den_val", lden, dn);
      end
      chk("acc_finished", nfin, 1);
      chk("out_req_seen", seen_out, !acc_only);
      chk("acc_only_fld", nacc_bad, 0);
      if (acc_only) begin exp_max = fmax; exp_den = fden; end
      chk("max_o", max_out, exp_max);
      chk("den_o", den_out, exp_den);
`ifdef SFM_CTRL_PERF_CNT_EN
      chk("cycles", cycles, nbusy);
`else
      chk("cycles", cycles, 0);
`endif
      if (cmd[2]) model_first = 1'b1;
      @(negedge clk);
      chk("done_pulse_end", done, 0);
      chk("busy_end", busy, 0);
   endtask

   initial begin
      bit seen;
      rst = 1'b1; tot_len = '0; commands = '0;
      max_in = '0; den_in = '0;
      idle_inputs();
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ctrl", ctrl, '0);
      chk("rst_req", {in_req, out_req}, 0);
      chk("rst_max", max_out, 0);
      rst = 1'b0;

      run_cmd(16, 3'b100, $urandom, $urandom, 0);
      run_cmd(9, 3'b001, $urandom, $urandom, 0);
      run_cmd(20, 3'b001, $urandom, $urandom, 0);
      run_cmd(8, 3'b101, $urandom, $urandom, 0);
      run_cmd(33, 3'b001, $urandom, $urandom, 0);
      run_cmd(16, 3'b010, 32'h3F80_0000, 32'h4000_0000, 0);
      run_cmd(40, 3'b100, $urandom, $urandom, 1);
      run_cmd(12, 3'b011, $urandom, $urandom, 0);

      // zero length: done next cycle, never busy; start on done ignored
      @(negedge clk);
      start = 1'b1; tot_len = 0; commands = 3'b100;
      @(negedge clk);
      chk("len0_done", done, 1);
      chk("len0_busy", busy, 0);
      model_first = 1'b1;
      start = 1'b1; tot_len = 16; commands = 3'b000;
      @(negedge clk);
      start = 1'b0;
      chk("start_on_done_busy", busy, 0);
      chk("start_on_done_done", done, 0);

      for (int k = 0; k < 8; k++)
         run_cmd($urandom_range(1, 100), 3'($urandom_range(0, 7)),
                 $urandom, $urandom, 0);

      // reset while dividing
      @(negedge clk);
      start = 1'b1; tot_len = 24; commands = 3'b100;
      seen = 0;
      for (int n = 0; n < 500 && !seen; n++) begin
         @(negedge clk);
         start = 1'b0;
         seen = ctrl.dividing;
         in_beat = in_req;
         flags.accumulator_flags.inv_done = 1'b1;
      end
      chk("reached_div", seen, 1);
      rst = 1'b1;
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ctrl", ctrl, '0);
      chk("mid_rst_req", {in_req, out_req, done}, 0);
      chk("mid_rst_cyc", cycles, 0);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      chk("no_done_after_rst", seen, 0);
      model_first = 1'b1; exp_max = '0; exp_den = '0;
      run_cmd(10, 3'b001, $urandom, $urandom, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
